// File: rtl/br_arb_wrr_pkg.sv
// br_arb_wrr_pkg: shared helpers for the weighted round-robin arbiter.
package br_arb_wrr_pkg;

    function automatic int unsigned clamped_clog2(input int unsigned n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

    // A configured weight of zero behaves as a weight of one.
    function automatic int unsigned effective_weight(input int unsigned w);
        return (w == 0) ? 1 : w;
    endfunction

    // Circular increment. The wrap is explicit so it is correct for any flow count.
    function automatic int unsigned next_ptr(input int unsigned p, input int unsigned n);
        return (p == n - 1) ? 0 : p + 1;
    endfunction

endpackage

// File: rtl/br_arb_wrr_rotate_prio.sv
// br_arb_wrr_rotate_prio: combinational circular priority find-first that starts at ptr.
module br_arb_wrr_rotate_prio
    import br_arb_wrr_pkg::*;
#(
    parameter int unsigned NumFlows = 2,
    parameter int unsigned PtrWidth = 1
) (
    input  logic [PtrWidth-1:0] ptr,
    input  logic [NumFlows-1:0] request,
    output logic [NumFlows-1:0] can_grant,
    output logic [NumFlows-1:0] grant
);

    logic [NumFlows-1:0] req_rot, cg_rot;

    // Rotate so ptr sits at bit 0, find first, then rotate back.
    always_comb begin
        req_rot = NumFlows'({request, request} >> ptr);
        cg_rot = '0;
        cg_rot[0] = 1'b1;
        for (int k = 1; k < NumFlows; k++) cg_rot[k] = cg_rot[k-1] & ~req_rot[k-1];
        can_grant = NumFlows'(({cg_rot, cg_rot} << ptr) >> NumFlows);
        grant = can_grant & request;
    end

endmodule

// File: rtl/br_arb_weighted_rr.sv
// br_arb_weighted_rr: weighted round-robin arbiter, up to cfg_weight[i] back-to-back grants per flow.
// Define BR_ARB_WRR_GRANT_COUNT_EN to add saturating per-flow grant counters (stat_grant_count).
module br_arb_weighted_rr
    import br_arb_wrr_pkg::*;
#(
    parameter int unsigned NumFlows = 2,
    parameter int unsigned WeightWidth = 4,
    parameter int unsigned StatWidth = 16
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic [NumFlows-1:0]             request,
    input  logic                            enable_priority_update,
    input  logic [NumFlows*WeightWidth-1:0] cfg_weight,
    output logic [NumFlows-1:0]             can_grant,
    output logic [NumFlows-1:0]             grant
`ifdef BR_ARB_WRR_GRANT_COUNT_EN
    ,
    output logic [NumFlows*StatWidth-1:0]   stat_grant_count
`endif
);

    localparam int unsigned PtrWidth = clamped_clog2(NumFlows);

    if (NumFlows < 2 || WeightWidth < 1 || StatWidth < 1) begin : g_bad_params
        $error("br_arb_weighted_rr: illegal parameters");
    end

    logic [PtrWidth-1:0]    ptr, g;
    logic [WeightWidth-1:0] used, wg;
    logic [WeightWidth:0]   n;
    logic                   upd, done;

    br_arb_wrr_rotate_prio #(.NumFlows(NumFlows), .PtrWidth(PtrWidth)) u_prio (
        .ptr      (ptr),
        .request  (request),
        .can_grant(can_grant),
        .grant    (grant)
    );

    always_comb begin
        g = '0;
        wg = '0;
        for (int i = 0; i < NumFlows; i++) begin
            if (grant[i]) begin
                g = PtrWidth'(i);
                wg = cfg_weight[i*WeightWidth +: WeightWidth];
            end
        end
        upd = enable_priority_update && |grant;
        // A winner other than ptr starts a fresh burst; the abandoned one is dropped.
        n = (g == ptr) ? (WeightWidth + 1)'(used) + (WeightWidth + 1)'(1) : (WeightWidth + 1)'(1);
        done = 32'(n) >= effective_weight(32'(wg));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr <= '0;
            used <= '0;
        end else if (upd) begin
            ptr <= done ? PtrWidth'(next_ptr(32'(g), NumFlows)) : g;
            used <= done ? '0 : n[WeightWidth-1:0];
        end
    end

`ifdef BR_ARB_WRR_GRANT_COUNT_EN
    for (genvar i = 0; i < NumFlows; i++) begin : g_stat
        logic [StatWidth-1:0] cnt;
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) cnt <= '0;
            else if (upd && grant[i] && !(&cnt)) cnt <= cnt + StatWidth'(1);
        end
        assign stat_grant_count[i*StatWidth +: StatWidth] = cnt;
    end
`endif

    a_grant_onehot0: assert property (@(posedge clk) disable iff (!rst_n)
        $onehot0(grant) && ((grant & ~request) == '0));
    a_req_grant: assert property (@(posedge clk) disable iff (!rst_n) |request |-> |grant);
    a_ptr_range: assert property (@(posedge clk) disable iff (!rst_n) 32'(ptr) < NumFlows);

endmodule

// File: tb/tb_br_arb_weighted_rr.sv
// tb_br_arb_weighted_rr: directed vector bench for br_arb_weighted_rr (3-flow and 2-flow instances).
module tb_br_arb_weighted_rr;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic [2:0]  req3, g3, cg3;
    logic        upd3;
    logic [11:0] w3;
    logic [1:0]  req2, g2, cg2;
    logic        upd2;
    logic [7:0]  w2;
`ifdef BR_ARB_WRR_GRANT_COUNT_EN
    logic [47:0] stat3;
    logic [3:0]  stat2;
`endif

    br_arb_weighted_rr #(.NumFlows(3), .WeightWidth(4), .StatWidth(16)) u3 (
        .clk(clk), .rst_n(rst_n), .request(req3), .enable_priority_update(upd3),
        .cfg_weight(w3), .can_grant(cg3), .grant(g3)
`ifdef BR_ARB_WRR_GRANT_COUNT_EN
        , .stat_grant_count(stat3)
`endif
    );

    br_arb_weighted_rr #(.NumFlows(2), .WeightWidth(4), .StatWidth(2)) u2 (
        .clk(clk), .rst_n(rst_n), .request(req2), .enable_priority_update(upd2),
        .cfg_weight(w2), .can_grant(cg2), .grant(g2)
`ifdef BR_ARB_WRR_GRANT_COUNT_EN
        , .stat_grant_count(stat2)
`endif
    );

    typedef struct {
        bit          three;
        logic [2:0]  req;
        logic        upd;
        logic [11:0] w;
        logic [2:0]  eg;
        logic [2:0]  ecg;
    } vec_t;

    vec_t v[$];
    int nvec = 0;
    int nerr = 0;

    task automatic chk(input string nm, input int idx, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s[%0d] got %0h want %0h", nm, idx, act, exp);
        end
    endtask

    task automatic add(input bit t, input logic [2:0] r, input logic u, input logic [11:0] w,
                       input logic [2:0] eg, input logic [2:0] ecg);
        v.push_back('{t, r, u, w, eg, ecg});
    endtask

    initial begin
        rst_n = 1'b0;
        req3 = '0; upd3 = 1'b0; w3 = 12'h111;
        req2 = '0; upd2 = 1'b0; w2 = 8'h13;
        // Weights {1,1,1}: plain rotation 0,1,2,0.
        add(1, 3'b111, 1, 12'h111, 3'b001, 3'b001);
        add(1, 3'b111, 1, 12'h111, 3'b010, 3'b010);
        add(1, 3'b111, 1, 12'h111, 3'b100, 3'b100);
        add(1, 3'b111, 1, 12'h111, 3'b001, 3'b001);
        // ptr=1 now: partial request patterns with circular wrap.
        add(1, 3'b101, 1, 12'h111, 3'b100, 3'b110);
        add(1, 3'b110, 1, 12'h111, 3'b010, 3'b011);
        add(1, 3'b011, 1, 12'h111, 3'b001, 3'b101);
        add(1, 3'b000, 1, 12'h111, 3'b000, 3'b111);
        // Weights {3,1}.
        for (int k = 0; k < 2; k++) begin
            add(0, 3'b011, 1, 12'h013, 3'b001, 3'b001);
            add(0, 3'b011, 1, 12'h013, 3'b001, 3'b001);
            add(0, 3'b011, 1, 12'h013, 3'b001, 3'b001);
            add(0, 3'b011, 1, 12'h013, 3'b010, 3'b010);
        end
        add(0, 3'b000, 1, 12'h013, 3'b000, 3'b011);
        // Weights {4,1}: flow 0 drops after 2 grants, then gets a fresh 4-grant burst.
        add(0, 3'b011, 1, 12'h014, 3'b001, 3'b001);
        add(0, 3'b011, 1, 12'h014, 3'b001, 3'b001);
        add(0, 3'b010, 1, 12'h014, 3'b010, 3'b011);
        for (int k = 0; k < 4; k++) add(0, 3'b011, 1, 12'h014, 3'b001, 3'b001);
        add(0, 3'b011, 1, 12'h014, 3'b010, 3'b010);
        // Weights {2,2}: update held off for 5 cycles, then two grants to flow 0.
        for (int k = 0; k < 5; k++) add(0, 3'b011, 0, 12'h022, 3'b001, 3'b001);
        add(0, 3'b011, 1, 12'h022, 3'b001, 3'b001);
        add(0, 3'b011, 1, 12'h022, 3'b001, 3'b001);
        add(0, 3'b011, 1, 12'h022, 3'b010, 3'b010);
        add(0, 3'b011, 1, 12'h022, 3'b010, 3'b010);
        add(0, 3'b011, 1, 12'h022, 3'b001, 3'b001);
        // Weights {0,2}: flow 0 acts as weight 1.
        add(0, 3'b011, 1, 12'h020, 3'b001, 3'b001);
        add(0, 3'b011, 1, 12'h020, 3'b010, 3'b010);
        add(0, 3'b011, 1, 12'h020, 3'b010, 3'b010);
        add(0, 3'b011, 1, 12'h020, 3'b001, 3'b001);
        add(0, 3'b011, 1, 12'h020, 3'b010, 3'b010);

        #12 rst_n = 1'b1;
        @(posedge clk); #1;
        foreach (v[i]) begin
            if (v[i].three) begin
                req3 = v[i].req; upd3 = v[i].upd; w3 = v[i].w;
                req2 = '0; upd2 = 1'b0;
            end else begin
                req2 = v[i].req[1:0]; upd2 = v[i].upd; w2 = v[i].w[7:0];
                req3 = '0; upd3 = 1'b0;
            end
            #2;
            if (v[i].three) begin
                chk("grant3", i, 32'(g3), 32'(v[i].eg));
                chk("can_grant3", i, 32'(cg3), 32'(v[i].ecg));
            end else begin
                chk("grant2", i, 32'(g2), 32'(v[i].eg[1:0]));
                chk("can_grant2", i, 32'(cg2), 32'(v[i].ecg[1:0]));
            end
            @(posedge clk); #1;
        end

        // Mid-burst asynchronous reset: ptr=1, used=1 before it.
        req2 = 2'b11; upd2 = 1'b0;
        #1 chk("pre_rst_grant", 0, 32'(g2), 32'h2);
        #1 rst_n = 1'b0;
        #1;
        chk("rst_ptr", 0, 32'(u2.ptr), 32'h0);
        chk("rst_used", 0, 32'(u2.used), 32'h0);
        chk("rst_grant", 0, 32'(g2), 32'h1);
        #2 rst_n = 1'b1;
        @(posedge clk); #1;
        upd2 = 1'b1;
        #2 chk("post_rst_grant", 0, 32'(g2), 32'h1);
        @(posedge clk); #1;

`ifdef BR_ARB_WRR_GRANT_COUNT_EN
        rst_n = 1'b0;
        #2 rst_n = 1'b1;
        @(posedge clk); #1;
        req2 = 2'b01; upd2 = 1'b1; w2 = 8'h14;
        for (int k = 1; k <= 5; k++) begin
            @(posedge clk); #1;
            chk("stat_count", k, 32'(stat2), (k < 3) ? k : 3);
        end
`endif

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
